// File: rtl/i2c_reg_sequencer.sv
// Register-level request sequencer feeding an I2C master engine: turns one host
// read/write request into one or two master transactions and returns one response.
module i2c_reg_sequencer #(
    parameter int unsigned MAX_LEN       = 4,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_write_i,
    input  logic [6:0]                   req_dev_addr_i,
    input  logic [7:0]                   req_reg_addr_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] req_len_i,
    input  logic [8*MAX_LEN-1:0]         req_wdata_i,
    output logic                         resp_valid_o,
    output logic [8*MAX_LEN-1:0]         resp_rdata_o,
    output logic                         resp_error_o,
    output logic                         cmd_strobe_o,
    output logic [7:0]                   ctrl_wr_o,
    output logic [31:0]                  len_rd_o,
    output logic                         data_available_o,
    output logic [7:0]                   data_o,
    input  logic                         data_read_i,
    input  logic                         data_valid_i,
    input  logic [7:0]                   data_i,
    input  logic                         busy_i,
    input  logic                         error_i,
    output logic                         ack_error_o
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned DATA_W = 8 * MAX_LEN;
    localparam int unsigned PTR_W  = $clog2(MAX_LEN + 2);
    localparam int unsigned TMO_W  = $clog2(START_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, W_STRB, W_WAIT, W_RUN, R_STRB, R_WAIT, R_RUN, ERR_ACK, RESP
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [6:0]          dev_q, dev_d;
    logic [7:0]          reg_q, reg_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]    rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic                strobe_q, strobe_d;
    logic [7:0]          ctrl_q, ctrl_d;
    logic [31:0]         len_rd_q, len_rd_d;
    logic                avail_q, avail_d;
    logic [7:0]          data_q, data_d;
    logic                ack_q, ack_d;

    logic                ready_c;
    logic [LEN_W-1:0]    len_clamp_c;
    logic [PTR_W-1:0]    plen_c;

    // Write-phase payload: byte 0 is the register address, then write data LSB first.
    function automatic logic [7:0] payload_byte(input logic [PTR_W-1:0]  idx,
                                                input logic [7:0]        reg_addr,
                                                input logic [DATA_W-1:0] wdata);
        logic [7:0] b;
        b = 8'h00;
        if (idx == '0) b = reg_addr;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx == PTR_W'(i + 1)) b = wdata[8*i +: 8];
        end
        return b;
    endfunction

    assign ready_c = (state_q == IDLE) && !busy_i && !error_i;
    assign plen_c  = write_q ? (PTR_W'(len_q) + PTR_W'(1)) : PTR_W'(1);

    always_comb begin
        if (req_len_i == '0)                    len_clamp_c = LEN_W'(1);
        else if (req_len_i > LEN_W'(MAX_LEN))   len_clamp_c = LEN_W'(MAX_LEN);
        else                                    len_clamp_c = req_len_i;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        ptr_d      = ptr_q;
        rd_idx_d   = rd_idx_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        resp_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && ready_c) begin
                    write_d  = req_write_i;
                    dev_d    = req_dev_addr_i;
                    reg_d    = req_reg_addr_i;
                    len_d    = len_clamp_c;
                    wdata_d  = req_wdata_i;
                    ptr_d    = '0;
                    rd_idx_d = '0;
                    rdata_d  = '0;
                    state_d  = W_STRB;
                end
            end
            W_STRB, R_STRB: begin
                tmo_d   = '0;
                state_d = (state_q == W_STRB) ? W_WAIT : R_WAIT;
            end
            W_WAIT, R_WAIT: begin
                if (busy_i) begin
                    state_d = (state_q == W_WAIT) ? W_RUN : R_RUN;
                end else if (tmo_q == TMO_W'(START_TIMEOUT)) begin
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            W_RUN: begin
                if (data_read_i && (ptr_q < plen_c)) ptr_d = ptr_q + PTR_W'(1);
                if (!busy_i) begin
                    if (error_i)      state_d = ERR_ACK;
                    else if (write_q) state_d = RESP;
                    else              state_d = R_STRB;
                end
            end
            R_RUN: begin
                // Capture first so a byte landing with the busy fall still counts.
                if (data_valid_i && (rd_idx_q < len_q)) begin
                    for (int unsigned b = 0; b < MAX_LEN; b++) begin
                        if (rd_idx_q == LEN_W'(b)) rdata_d[8*b +: 8] = data_i;
                    end
                    rd_idx_d = rd_idx_q + LEN_W'(1);
                end
                if (!busy_i) begin
                    if (error_i) begin
                        state_d = ERR_ACK;
                    end else begin
                        resp_err_d = (rd_idx_d != len_q);
                        state_d    = RESP;
                    end
                end
            end
            ERR_ACK: begin
                resp_err_d = 1'b1;
                state_d    = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        strobe_d     = (state_d == W_STRB) || (state_d == R_STRB);
        resp_valid_d = (state_d == RESP);
        ack_d        = (state_d == ERR_ACK) || ((state_d == IDLE) && error_i);

        ctrl_d   = ctrl_q;
        len_rd_d = len_rd_q;
        if (state_d == W_STRB) begin
            ctrl_d   = {dev_d, 1'b0};
            len_rd_d = 32'd0;
        end else if (state_d == R_STRB) begin
            ctrl_d   = {dev_d, 1'b1};
            len_rd_d = 32'(len_d);
        end else if ((state_d == ERR_ACK) || (state_d == RESP) || (state_d == IDLE)) begin
            ctrl_d   = 8'h00;
            len_rd_d = 32'd0;
        end

        avail_d = (state_d == W_RUN) && (ptr_d < plen_c);
        data_d  = avail_d ? payload_byte(ptr_d, reg_d, wdata_d) : 8'h00;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            dev_q        <= '0;
            reg_q        <= '0;
            len_q        <= '0;
            wdata_q      <= '0;
            ptr_q        <= '0;
            rd_idx_q     <= '0;
            tmo_q        <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            strobe_q     <= 1'b0;
            ctrl_q       <= '0;
            len_rd_q     <= '0;
            avail_q      <= 1'b0;
            data_q       <= '0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            dev_q        <= dev_d;
            reg_q        <= reg_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            ptr_q        <= ptr_d;
            rd_idx_q     <= rd_idx_d;
            tmo_q        <= tmo_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            strobe_q     <= strobe_d;
            ctrl_q       <= ctrl_d;
            len_rd_q     <= len_rd_d;
            avail_q      <= avail_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
        end
    end

    assign req_ready_o      = ready_c;
    assign resp_valid_o     = resp_valid_q;
    assign resp_rdata_o     = rdata_q;
    assign resp_error_o     = resp_err_q;
    assign cmd_strobe_o     = strobe_q;
    assign ctrl_wr_o        = ctrl_q;
    assign len_rd_o         = len_rd_q;
    assign data_available_o = avail_q;
    assign data_o           = data_q;
    assign ack_error_o      = ack_q;

endmodule
